// File: rtl/msc4_pkg.sv
// MSC-4 fetch sequencer shared types: phase encoding and opcode fields.
// HALTED phase is reachable only when built with MSC4_HALT_EN.
package msc4_pkg;

  typedef enum logic [3:0] {
    PH_A1     = 4'd0,
    PH_A2     = 4'd1,
    PH_A3     = 4'd2,
    PH_M1     = 4'd3,
    PH_M2     = 4'd4,
    PH_X1     = 4'd5,
    PH_X2     = 4'd6,
    PH_X3     = 4'd7,
    PH_HALTED = 4'd8
  } phase_e;

  localparam logic [3:0] OPR_IO  = 4'hE;
  localparam logic [3:0] OPA_WRR = 4'h2;
  localparam logic [3:0] OPA_RDR = 4'hA;
  localparam logic [3:0] OPR_SRC = 4'h2;

endpackage

// File: rtl/msc4_fetch_sequencer_pc_unit.sv
// Program counter: reset value, increment or load once per instruction.
// Arithmetic is naturally mod 4096, so 12'hFFF steps to 12'h000.
module msc4_pc_unit #(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  input  logic        load,
  input  logic [11:0] load_addr,
  output logic [11:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RESET;
    end else if (adv) begin
      pc <= load ? load_addr : pc + 12'd1;
    end
  end

endmodule

// File: rtl/msc4_fetch_sequencer.sv
// MSC-4 bus sequencer: 8-phase fetch/execute cycle toward Intel-4001 ROMs.
// Build option MSC4_HALT_EN enables the HALT input and HALTED phase.
module msc4_fetch_sequencer
  import msc4_pkg::*;
#(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        CLK0,
  input  logic        RESET,
  input  logic [3:0]  D_IN,
  output logic [3:0]  D_OUT,
  output logic        D_OE,
  output logic        SYNC,
  output logic        CM_ROM,
  input  logic [3:0]  ACC_IN,
  input  logic [3:0]  SRC_DATA,
  output logic [3:0]  ACC_OUT,
  output logic        ACC_WE,
  input  logic        JUMP_EN,
  input  logic [11:0] JUMP_ADDR,
  input  logic        HALT,
  output logic [7:0]  INSTR,
  output logic        INSTR_VALID,
  output logic [11:0] PC
);

  phase_e     phase;
  phase_e     phase_nxt;
  logic [3:0] opr;
  logic       is_wrr;
  logic       is_rdr;
  logic       is_src;

  logic       sync_d;
  logic       cm_d;
  logic       oe_d;
  logic [3:0] dout_d;
  logic       valid_d;
  logic       we_d;

  assign is_wrr = INSTR == {OPR_IO, OPA_WRR};
  assign is_rdr = INSTR == {OPR_IO, OPA_RDR};
  assign is_src = (INSTR[7:4] == OPR_SRC) && INSTR[0];

  msc4_pc_unit #(
    .PC_RESET(PC_RESET)
  ) u_pc (
    .clk      (CLK0),
    .rst_n    (RESET),
    .adv      (phase == PH_X3),
    .load     (JUMP_EN),
    .load_addr(JUMP_ADDR),
    .pc       (PC)
  );

`ifndef MSC4_HALT_EN
  logic unused_halt;
  assign unused_halt = HALT;
`endif

  always_comb begin
    phase_nxt = PH_A1;
    unique case (phase)
      PH_A1:   phase_nxt = PH_A2;
      PH_A2:   phase_nxt = PH_A3;
      PH_A3:   phase_nxt = PH_M1;
      PH_M1:   phase_nxt = PH_M2;
      PH_M2:   phase_nxt = PH_X1;
      PH_X1:   phase_nxt = PH_X2;
      PH_X2:   phase_nxt = PH_X3;
`ifdef MSC4_HALT_EN
      PH_X3:     phase_nxt = HALT ? PH_HALTED : PH_A1;
      PH_HALTED: phase_nxt = HALT ? PH_HALTED : PH_A1;
`endif
      default: phase_nxt = PH_A1;
    endcase
  end

  always_ff @(posedge CLK0 or negedge RESET) begin
    if (!RESET) begin
      phase   <= PH_A1;
      opr     <= 4'h0;
      INSTR   <= 8'h00;
      ACC_OUT <= 4'h0;
    end else begin
      phase <= phase_nxt;
      if (phase == PH_M1) opr <= D_IN;
      if (phase == PH_M2) INSTR <= {opr, D_IN};
      if (phase == PH_X2 && is_rdr) ACC_OUT <= D_IN;
    end
  end

  always_comb begin
    sync_d  = 1'b1;
    cm_d    = 1'b1;
    oe_d    = 1'b0;
    dout_d  = 4'h0;
    valid_d = 1'b0;
    we_d    = 1'b0;
    unique case (phase)
      PH_A1: begin
        sync_d = 1'b0;
        oe_d   = 1'b1;
        dout_d = PC[3:0];
      end
      PH_A2: begin
        oe_d   = 1'b1;
        dout_d = PC[7:4];
      end
      PH_A3: begin
        oe_d   = 1'b1;
        dout_d = PC[11:8];
        cm_d   = 1'b0;
      end
      PH_M2: cm_d = (opr != OPR_IO);
      PH_X1: valid_d = 1'b1;
      PH_X2: begin
        unique case (1'b1)
          is_wrr: begin
            oe_d   = 1'b1;
            dout_d = ACC_IN;
          end
          is_src: begin
            cm_d   = 1'b0;
            oe_d   = 1'b1;
            dout_d = SRC_DATA;
          end
          default: ;
        endcase
      end
      PH_X3: we_d = is_rdr;
      default: ;
    endcase
  end

  // Phase resets to A1, whose decode drives the bus; mask while held.
  assign SYNC        = ~RESET | sync_d;
  assign CM_ROM      = ~RESET | cm_d;
  assign D_OE        = RESET & oe_d;
  assign D_OUT       = RESET ? dout_d : 4'h0;
  assign INSTR_VALID = RESET & valid_d;
  assign ACC_WE      = RESET & we_d;

endmodule

// File: doc/msc4_fetch_sequencer.md
Name: msc4_fetch_sequencer

Overview:
CPU-side bus sequencer for the MSC-4 4-bit data bus: runs the 8-phase instruction cycle (A1,A2,A3,M1,M2,X1,X2,X3), one CLK0 cycle per phase. It drives the 12-bit program address onto the bus, strobes CM_ROM, and captures the 8-bit instruction returned by the Intel-4001 ROMs. It also sequences 4001 I/O transfers (WRR, RDR, SRC) in the X phases. It sits between the execution unit and up to 16 Intel-4001 chips.

Parameters:
PC_RESET, 12'h000, program counter value after reset

Ports:
CLK0  in  1  phase clock; all state updates on rising edge
RESET  in  1  asynchronous reset, active-low
D_IN  in  4  data bus sampled from ROMs
D_OUT  out  4  data bus value driven by sequencer
D_OE  out  1  bus drive enable for D_OUT
SYNC  out  1  active-low cycle marker; low only during A1
CM_ROM  out  1  active-low ROM command/select strobe
ACC_IN  in  4  accumulator value from execution unit (WRR source)
SRC_DATA  in  4  register-pair high nibble (SRC source)
ACC_OUT  out  4  nibble read by RDR
ACC_WE  out  1  one-cycle write strobe for ACC_OUT
JUMP_EN  in  1  load JUMP_ADDR instead of incrementing (sampled end of X3)
JUMP_ADDR  in  12  jump target
HALT  in  1  stop request (only with MSC4_HALT_EN)
INSTR  out  8  {OPR,OPA} of last fetched instruction
INSTR_VALID  out  1  one-cycle pulse during X1
PC  out  12  current program counter

Behaviour:
- "End of phase P" means the rising CLK0 edge that leaves P. Outputs are Moore-decoded from the phase register.
- Reset (RESET=0, async): phase=A1, PC=PC_RESET, INSTR=0, ACC_OUT=0, INSTR_VALID=0, ACC_WE=0, D_OE=0, D_OUT=0, CM_ROM=1, SYNC=1. While RESET=0, all outputs are forced to these values. Any partial instruction is discarded and ACC_WE is never asserted.
- Phase transitions: A1->A2->A3->M1->M2->X1->X2->X3->A1, unconditional except for HALT (see Optional Feature).
- A1: SYNC=0, D_OE=1, D_OUT=PC[3:0].
- A2: D_OE=1, D_OUT=PC[7:4].
- A3: D_OE=1, D_OUT=PC[11:8] (chip select), CM_ROM=0.
- M1: D_OE=0; OPR<=D_IN at end of M1.
- M2: D_OE=0; OPA<=D_IN at end of M2. If OPR==4'hE (I/O group), CM_ROM=0 during M2.
- X1: INSTR={OPR,OPA}, INSTR_VALID=1 for exactly this cycle.
- X2, WRR (8'hE2): D_OE=1, D_OUT=ACC_IN.
- X2, RDR (8'hEA): D_OE=0; ACC_OUT<=D_IN at end of X2.
- X2, SRC (OPR=4'h2, OPA[0]=1): CM_ROM=0, D_OE=1, D_OUT=SRC_DATA.
- X2, all other instructions: bus idle, CM_ROM=1.
- X3: ACC_WE=1 only if the instruction was RDR. At end of X3: PC<=JUMP_EN ? JUMP_ADDR : PC+1, mod 4096 (12'hFFF wraps to 12'h000).
- CM_ROM is 1 and D_OE is 0 in every case not listed above.
- INSTR holds its value until the next end-of-M2 update.

Optional Feature:
MSC4_HALT_EN.
- Defined: HALT sampled at end of X3. If HALT=1, the sequencer enters the HALTED phase after the PC update, so a simultaneous JUMP_EN still loads the target. In HALTED: D_OE=0, SYNC=1, CM_ROM=1, PC held. When HALT is sampled 0, the next phase is A1. Reset exits HALTED.
- Undefined: the HALT port is present but ignored, and the HALTED phase does not exist.

Decomposition:
- Package msc4_pkg: phase encoding (A1..X3 = 0..7, HALTED = 8, 4-bit), OPR_IO=4'hE, OPA_WRR=4'h2, OPA_RDR=4'hA, OPR_SRC=4'h2.
- Sub-module msc4_pc_unit: 12-bit PC with reset value, increment, load and wrap.
- Phase FSM and bus decode stay in the top module.

Test Plan:
- Release reset, ROM model returns 8'h12 at address 0 -> D_OUT 0,0,0 in A1-A3; SYNC low only in A1; CM_ROM low only in A3; INSTR=8'h12 with INSTR_VALID in X1; PC=1 after X3.
- ROM returns 8'hE2, ACC_IN=4'h5 -> CM_ROM low in A3 and M2; in X2 D_OE=1 and D_OUT=4'h5; ACC_WE stays 0.
- ROM returns 8'hEA, D_IN=4'h9 in X2 -> ACC_OUT=4'h9; ACC_WE high for X3 only.
- JUMP_EN=1, JUMP_ADDR=12'h3FF at X3 -> next A1-A3 drive F,F,3.
- PC=12'hFFF with no jump -> next cycle drives 0,0,0.
- RESET low during M2 -> outputs immediately take reset values; after release the sequencer restarts at A1 with PC=PC_RESET; no INSTR_VALID for the aborted fetch.
